// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the note-timing judge and its score consumer.
package hit_judge_pkg;

    localparam int unsigned JUDGE_W = 2;
    localparam int unsigned COMBO_W = 8;
    localparam int unsigned WIN_W   = 8;
    localparam int unsigned CMP_W   = WIN_W + 1;

    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    typedef enum logic [JUDGE_W-1:0] {
        JUDGE_MISS    = 2'b00,
        JUDGE_EARLY   = 2'b01,
        JUDGE_LATE    = 2'b10,
        JUDGE_PERFECT = 2'b11
    } judge_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    typedef struct packed {
        judge_e               inp;
        logic [COMBO_W-1:0]   combo;
    } judge_pkt_t;

    // Classify a press by its signed distance from the note centre.
    function automatic judge_e judge_of(input logic [WIN_W-1:0] win,
                                        input int unsigned      half,
                                        input int unsigned      perf);
        logic signed [CMP_W-1:0] d;
        logic signed [CMP_W-1:0] mag;
        d   = $signed({1'b0, win}) - $signed(CMP_W'(half));
        mag = (d < 0) ? -d : d;
        if (mag <= $signed(CMP_W'(perf)))
            return JUDGE_PERFECT;
        else if (d < 0)
            return JUDGE_EARLY;
        else
            return JUDGE_LATE;
    endfunction

    function automatic logic [COMBO_W-1:0] combo_inc(input logic [COMBO_W-1:0] c);
        return (c == COMBO_MAX) ? c : c + COMBO_W'(1);
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Score-side bundle: note/key stimulus in, judgement and combo out.
interface hit_judge_if;
    import hit_judge_pkg::*;

    logic               note_start;
    logic               key;
    logic [JUDGE_W-1:0] Inp;
    logic               judge_valid;
    logic [COMBO_W-1:0] combo;
    logic               armed;

    modport master (
        input  note_start,
        input  key,
        output Inp,
        output judge_valid,
        output combo,
        output armed
    );

    modport slave (
        output note_start,
        output key,
        input  Inp,
        input  judge_valid,
        input  combo,
        input  armed
    );
endinterface

// File: rtl/hit_judge_key_sync_edge.sv
// Three-flop synchroniser for the raw key with a rising-edge press strobe.
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic k1;
    logic k2;
    logic k3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k1 <= 1'b0;
            k2 <= 1'b0;
            k3 <= 1'b0;
        end else begin
            k1 <= key;
            k2 <= k1;
            k3 <= k2;
        end
    end

    // One press per key-down; holding the key does not retrigger.
    assign press = k2 & ~k3;

endmodule

// File: rtl/hit_judge.sv
// Note judge: opens a timing window per note and grades the first key press in it.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned HALF_WIN  = 100,
    parameter int unsigned PERF_HALF = 30
) (
    input  logic        clk,
    input  logic        reset,
    hit_judge_if.master bus
);

    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [WIN_W-1:0]   WIN_END    = WIN_W'(2 * HALF_WIN);

    logic [PRESC_W-1:0] presc_q;
    logic               tick_c;
    logic               press;

    state_e             state_q, state_n;
    logic [WIN_W-1:0]   win_q, win_n;
    judge_pkt_t         pkt_q, pkt_n;
    logic               valid_q, valid_n;
    logic               armed_q, armed_n;

    key_sync_edge u_key_sync (
        .clk   (clk),
        .reset (reset),
        .key   (bus.key),
        .press (press)
    );

    // Free-running timing-tick prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            presc_q <= '0;
        else if (tick_c)
            presc_q <= '0;
        else
            presc_q <= presc_q + PRESC_W'(1);
    end

    assign tick_c = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            pkt_q   <= '{inp: JUDGE_MISS, combo: '0};
            valid_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_n;
            win_q   <= win_n;
            pkt_q   <= pkt_n;
            valid_q <= valid_n;
            armed_q <= armed_n;
        end
    end

    // Priority inside a window: press, then a new note (MISS), then expiry tick.
    always_comb begin
        state_n   = state_q;
        win_n     = win_q;
        pkt_n.inp = JUDGE_MISS;
        pkt_n.combo = pkt_q.combo;
        valid_n   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.note_start) begin
                    state_n = ST_ARMED;
                    win_n   = '0;
                end
            end
            ST_ARMED: begin
                if (press) begin
                    valid_n     = 1'b1;
                    pkt_n.inp   = judge_of(win_q, HALF_WIN, PERF_HALF);
                    pkt_n.combo = combo_inc(pkt_q.combo);
                    if (bus.note_start)
                        win_n = '0;
                    else
                        state_n = ST_IDLE;
                end else if (bus.note_start) begin
                    valid_n     = 1'b1;
                    pkt_n.combo = '0;
                    win_n       = '0;
                end else if (tick_c) begin
                    if (win_q == WIN_END) begin
                        valid_n     = 1'b1;
                        pkt_n.combo = '0;
                        state_n     = ST_IDLE;
                    end else begin
                        win_n = win_q + WIN_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        armed_n = (state_n == ST_ARMED);
    end

    assign bus.Inp         = JUDGE_W'(pkt_q.inp);
    assign bus.judge_valid = valid_q;
    assign bus.combo       = pkt_q.combo;
    assign bus.armed       = armed_q;

endmodule

// File: tb/tb_hit_judge.sv
// Randomised and directed scoreboard bench for hit_judge with a cycle-indexed timing model.
module tb_hit_judge;

    localparam int TD = 4;
    localparam int H  = 10;
    localparam int P  = 3;

    typedef struct {
        int         cyc;
        logic [1:0] inp;
        int         combo;
    } exp_t;

    logic clk;
    logic reset;

    hit_judge_if bus();

    hit_judge #(.TICK_DIV(TD), .HALF_WIN(H), .PERF_HALF(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rbase  = 0;
    int   s      = 0;
    bit   open   = 0;
    int   combo_m = 0;
    bit   kd1 = 0, kd2 = 0, kd3 = 0;
    bit   exp_armed = 0;
    bit   in_reset  = 1;
    exp_t jq[$];
    exp_t mon_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_tick(input int c);
        return ((c - rbase) % TD) == TD - 1;
    endfunction

    // Window count seen during cycle c: ticks strictly between the note cycle and c.
    function automatic int win_at(input int c);
        int n = 0;
        for (int t = s + 1; t < c; t++)
            if (is_tick(t)) n++;
        return n;
    endfunction

    function automatic logic [1:0] grade(input int w);
        int d = w - H;
        if (d <= P && d >= -P) return 2'b11;
        if (d < 0) return 2'b01;
        return 2'b10;
    endfunction

    task automatic model(input bit ns, input bit k);
        bit press;
        int w;
        exp_armed = open;
        press = kd2 & ~kd3;
        if (open) begin
            w = win_at(cyc);
            if (press) begin
                combo_m = (combo_m >= 255) ? 255 : combo_m + 1;
                jq.push_back('{cyc: cyc + 1, inp: grade(w), combo: combo_m});
                if (ns) s = cyc;
                else    open = 0;
            end else if (ns) begin
                combo_m = 0;
                jq.push_back('{cyc: cyc + 1, inp: 2'b00, combo: 0});
                s = cyc;
            end else if (is_tick(cyc) && w == 2 * H) begin
                combo_m = 0;
                jq.push_back('{cyc: cyc + 1, inp: 2'b00, combo: 0});
                open = 0;
            end
        end else if (ns) begin
            open = 1;
            s = cyc;
        end
        kd3 = kd2;
        kd2 = kd1;
        kd1 = k;
    endtask

    task automatic step(input bit ns, input bit k);
        @(posedge clk);
        cyc++;
        #1;
        bus.note_start = ns;
        bus.key        = k;
        model(ns, k);
    endtask

    task automatic settle(input int n);
        repeat (n) step(0, 0);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (bus.Inp !== 2'b00 || bus.judge_valid !== 1'b0 || bus.combo !== 8'd0 || bus.armed !== 1'b0) begin
            errors++;
            $display("FAIL %s: got Inp=%b valid=%b combo=%0d armed=%b, need all zero",
                     tag, bus.Inp, bus.judge_valid, bus.combo, bus.armed);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        cyc++;
        #1;
        in_reset = 1;
        reset = 1'b0;
        bus.note_start = 1'b0;
        bus.key = 1'b0;
        #2;
        check_zero("reset_immediate");
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b1;
        rbase = cyc;
        open = 0;
        combo_m = 0;
        kd1 = 0; kd2 = 0; kd3 = 0;
        jq.delete();
        in_reset = 0;
        model(0, 0);
    endtask

    // Land a one-cycle key pulse so the synchronised press sees window count w.
    task automatic press_at(input int w, input bit note_with);
        int guard = 0;
        while (open && win_at(cyc + 3) < w && guard < 2000) begin
            step(0, 0);
            guard++;
        end
        step(0, 1);
        step(0, 0);
        step(note_with, 0);
    endtask

    task automatic press_on_expiry();
        int guard = 0;
        while (!(win_at(cyc + 3) == 2 * H && is_tick(cyc + 3)) && guard < 2000) begin
            step(0, 0);
            guard++;
        end
        step(0, 1);
        step(0, 0);
        step(0, 0);
    endtask

    task automatic key_pulse();
        step(0, 1);
        step(0, 0);
    endtask

    // Monitor: per-cycle armed check plus scoreboard pop on every judgement pulse.
    always @(negedge clk) begin
        if (!in_reset) begin
            checks++;
            if (bus.armed !== exp_armed) begin
                errors++;
                $display("FAIL armed cyc=%0d got=%b need=%b", cyc, bus.armed, exp_armed);
            end
            while (jq.size() > 0 && jq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_judge cyc=%0d got no pulse, need Inp=%b combo=%0d",
                         jq[0].cyc, jq[0].inp, jq[0].combo);
                void'(jq.pop_front());
            end
            checks++;
            if (bus.judge_valid) begin
                if (jq.size() == 0 || jq[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_judge cyc=%0d got Inp=%b combo=%0d, need no pulse",
                             cyc, bus.Inp, bus.combo);
                end else begin
                    mon_e = jq.pop_front();
                    if (bus.Inp !== mon_e.inp || bus.combo !== 8'(mon_e.combo)) begin
                        errors++;
                        $display("FAIL judge cyc=%0d got Inp=%b combo=%0d, need Inp=%b combo=%0d",
                                 cyc, bus.Inp, bus.combo, mon_e.inp, mon_e.combo);
                    end
                end
            end else if (bus.Inp !== 2'b00) begin
                errors++;
                $display("FAIL inp_idle cyc=%0d got Inp=%b, need 00", cyc, bus.Inp);
            end
        end
    end

    initial begin
        bit k;
        reset = 1'b1;
        bus.note_start = 1'b0;
        bus.key = 1'b0;
        #1 reset = 1'b0;
        #2 check_zero("power_on_reset");
        do_reset();
        settle(3);

        // Centre hit, then early/late/perfect-edge hits.
        step(1, 0); press_at(10, 0); settle(4);
        step(1, 0); press_at(5, 0);  settle(4);
        step(1, 0); press_at(15, 0); settle(4);
        step(1, 0); press_at(7, 0);  settle(4);
        step(1, 0); press_at(13, 0); settle(4);

        // Expiry with no press.
        step(1, 0); settle(21 * TD + 8);

        // Press in idle, second press in same window, long hold.
        key_pulse(); settle(4);
        step(1, 0); press_at(3, 0); settle(2); key_pulse(); settle(4);
        step(1, 0); press_at(10, 0);
        repeat (50) step(0, 1);
        settle(4);

        // New note while armed, then press at centre of the fresh window.
        step(1, 0);
        while (win_at(cyc + 1) < 4) step(0, 0);
        step(1, 0); press_at(10, 0); settle(4);

        // Simultaneous cases: press on expiry tick, note+press armed, note+press idle.
        step(1, 0); press_on_expiry(); settle(4);
        step(1, 0); press_at(8, 1); press_at(12, 0); settle(4);
        step(0, 1); step(0, 0); step(1, 0); settle(21 * TD + 8);

        // Reset mid-window with combo 9.
        repeat (9) begin step(1, 0); press_at(10, 0); settle(3); end
        step(1, 0);
        while (win_at(cyc + 1) < 6) step(0, 0);
        step(0, 0);
        do_reset();
        settle(3);

        // Saturation.
        repeat (260) begin step(1, 0); press_at(10, 0); settle(3); end
        checks++;
        if (bus.combo !== 8'(combo_m) || combo_m != 255) begin
            errors++;
            $display("FAIL combo_sat got=%0d need=255", bus.combo);
        end

        // Random traffic.
        k = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 9 == 0) k = ~k;
            step(($urandom % 50) == 0, k);
        end
        settle(10);

        checks++;
        if (jq.size() != 0) begin
            errors++;
            $display("FAIL pending_judge got %0d outstanding, need 0", jq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
